scaled_bg_renderer: RTL and testbench
=====================================

# scaled_bg_renderer

Parametrised full-screen background renderer for the VGA path. It maps each screen pixel (DrawX, DrawY) to a source-image texel by fixed-point scaling, not by division. It adds a horizontally wrapping scroll offset that is either loaded or auto-advanced once per frame, drives an external synchronous image ROM and palette, and outputs registered 4-bit RGB plus an opaque flag for layering under the player and obstacle sprites.

## Interface
Parameters:
- SRC_W, 500: source image width in texels.
- SRC_H, 500: source image height in texels.
- SCR_W, 640: active screen width.
- SCR_H, 480: active screen height.
- FRAC, 16: fractional bits of the scale steps.
- IDX_W, 4: palette index width.
- TRANSP_IDX, 0: palette index treated as transparent.
- Derived: AW = $clog2(SRC_W*SRC_H); XW = $clog2(SRC_W).

Ports:
- vga_clk, input, 1: the single clock.
- reset, input, 1: synchronous, active-high.
- DrawX, input, 10: current pixel column.
- DrawY, input, 10: current pixel row.
- blank, input, 1: 1 = active video.
- frame_tick, input, 1: one-cycle pulse at the start of vertical blanking.
- scroll_load, input, 1: on frame_tick, load scroll_value.
- scroll_value, input, XW: offset to load; must be < SRC_W.
- scroll_run, input, 1: on frame_tick, advance the offset by scroll_speed.
- scroll_speed, input, XW: texels per frame; must be < SRC_W.
- rom_address, output, AW: address to the external ROM (1-cycle synchronous read).
- rom_q, input, IDX_W: ROM data, valid one cycle after rom_address.
- pal_index, output, IDX_W: palette index (equals the registered rom_q).
- palette_red, palette_green, palette_blue, input, 4 each: combinational palette result for pal_index.
- red, green, blue, output, 4 each: pixel colour.
- opaque, output, 1: pixel is active and its index differs from TRANSP_IDX.
- scroll_off, output, XW: current scroll offset.

## Operation
- Constants: STEP_X = (SRC_W << FRAC) / SCR_W and STEP_Y = (SRC_H << FRAC) / SCR_H, both floored.
- Source coordinates: sx = (DrawX*STEP_X) >> FRAC and sy = (DrawY*STEP_Y) >> FRAC. Products are computed at full width with no truncation before the shift. sx is always < SRC_W and sy always < SRC_H for DrawX < SCR_W and DrawY < SCR_H.
- Horizontal wrap: wx = sx + scroll_off, minus SRC_W if the sum is ≥ SRC_W. A single conditional subtract suffices because both operands are < SRC_W.
- Address: rom_address = sy*SRC_W + wx.
- Scroll update happens only on frame_tick:
  - scroll_load = 1: scroll_off ← scroll_value. Load wins when scroll_load and scroll_run are both 1.
  - else scroll_run = 1: scroll_off ← (scroll_off + scroll_speed), wrapped modulo SRC_W by a single subtract.
  - else: scroll_off holds.
- Because scroll_off changes only in vertical blanking, no tearing occurs within a frame.
- Output rule: if the blank delayed to the output stage is 1, RGB comes from the palette. Otherwise RGB = 0 and opaque = 0.

## Timing
- Pipeline, with DrawX/DrawY/blank presented at cycle t:
  - S1 (t+1): registered sx, sy, blank.
  - S2 (t+2): registered rom_address and blank.
  - S3 (t+3): rom_q valid; pal_index = rom_q, registered together with blank.
  - S4 (t+4): red/green/blue/opaque registered.
- Fixed latency is 4 cycles. blank is delayed through a matching 4-stage shift register.
- scroll_off updates the cycle after frame_tick and is sampled in S1 to form wx.
- Reset: all pipeline registers, rom_address, pal_index, RGB, opaque and scroll_off go to 0.
  - The delayed blank chain clears, so outputs stay black for 4 cycles after reset deasserts.
  - Reset mid-frame discards in-flight pixels and causes no spurious colour.
- frame_tick during reset is ignored.

## Structure
- Package bg_render_pkg holds:
  - FRAC default and the step-constant function step(src, scr, frac).
  - Pipeline depth localparam PIPE_LAT = 4.
  - Struct px_stage_t with fields {sx, sy, blank}.
- Sub-module bg_scroll_ctrl holds the scroll_off register, load/run priority and modulo wrap.

## Test plan
- Scroll 0, DrawX=639, DrawY=479, blank=1 -> rom_address = 249499 at t+2; RGB = palette(rom_q) at t+4.
- scroll_value=10 loaded on frame_tick, then DrawX=639, DrawY=0 -> sx = 499 wraps to wx = 9, so rom_address = 9.
- scroll_off=498, scroll_speed=3, scroll_run=1, one frame_tick -> scroll_off = 1. With scroll_load=1 and scroll_value=7 in the same tick -> scroll_off = 7.
- blank=0 with rom_q = 5 -> red/green/blue = 0 and opaque = 0. blank=1 with rom_q = TRANSP_IDX -> opaque = 0 and RGB = palette colour.
- Reset asserted mid-line with blank=1 -> outputs 0 on the next cycle; 0 for 4 cycles after deassert; scroll_off = 0.
- Sweep all 640x480 pixels with SRC_W=SRC_H=500 -> rom_address always < 250000 and matches the reference model ((DrawX*51200)>>16) + ((DrawY*68266)>>16)*500.

Source files
------------

// File: rtl/bg_render_pkg.sv
// Shared constants, pipeline payload and fixed-point step helper for the
// scaled background renderer.
package bg_render_pkg;

    localparam int unsigned FRAC_DEF = 16;
    localparam int unsigned PIPE_LAT = 4;
    localparam int unsigned COORD_W  = 16;

    typedef struct packed {
        logic [COORD_W-1:0] sx;
        logic [COORD_W-1:0] sy;
        logic               blank;
    } px_stage_t;

    // Floored (src << frac) / scr, evaluated at 64 bits so large sources cannot overflow.
    function automatic int unsigned step(input int unsigned src,
                                         input int unsigned scr,
                                         input int unsigned frac);
        return 32'((64'(src) << frac) / 64'(scr));
    endfunction

endpackage

// File: rtl/bg_scroll_ctrl.sv
// Horizontal scroll offset: load or advance once per frame, wrapped modulo SRC_W.
module bg_scroll_ctrl #(
    parameter int unsigned SRC_W = 500,
    parameter int unsigned XW    = $clog2(SRC_W)
) (
    input  logic          vga_clk,
    input  logic          reset,
    input  logic          frame_tick,
    input  logic          scroll_load,
    input  logic [XW-1:0] scroll_value,
    input  logic          scroll_run,
    input  logic [XW-1:0] scroll_speed,
    output logic [XW-1:0] scroll_off
);

    localparam int unsigned SW = XW + 1;

    logic [XW-1:0] scroll_off_d, scroll_off_q;
    logic [SW-1:0] sum_c;

    // Load has priority over run; both operands are < SRC_W so one subtract wraps.
    always_comb begin
        scroll_off_d = scroll_off_q;
        sum_c        = SW'(scroll_off_q) + SW'(scroll_speed);
        if (sum_c >= SW'(SRC_W)) begin
            sum_c = sum_c - SW'(SRC_W);
        end
        if (frame_tick) begin
            if (scroll_load) begin
                scroll_off_d = scroll_value;
            end else if (scroll_run) begin
                scroll_off_d = XW'(sum_c);
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            scroll_off_q <= '0;
        end else begin
            scroll_off_q <= scroll_off_d;
        end
    end

    assign scroll_off = scroll_off_q;

endmodule

// File: rtl/scaled_bg_renderer.sv
// Full-screen background renderer: fixed-point screen-to-texel scaling, wrapping
// horizontal scroll, external sync ROM + palette, 4-cycle registered output.
module scaled_bg_renderer
    import bg_render_pkg::*;
#(
    parameter  int unsigned SRC_W      = 500,
    parameter  int unsigned SRC_H      = 500,
    parameter  int unsigned SCR_W      = 640,
    parameter  int unsigned SCR_H      = 480,
    parameter  int unsigned FRAC       = FRAC_DEF,
    parameter  int unsigned IDX_W      = 4,
    parameter  int unsigned TRANSP_IDX = 0,
    localparam int unsigned AW         = $clog2(SRC_W * SRC_H),
    localparam int unsigned XW         = $clog2(SRC_W)
) (
    input  logic             vga_clk,
    input  logic             reset,
    input  logic [9:0]       DrawX,
    input  logic [9:0]       DrawY,
    input  logic             blank,
    input  logic             frame_tick,
    input  logic             scroll_load,
    input  logic [XW-1:0]    scroll_value,
    input  logic             scroll_run,
    input  logic [XW-1:0]    scroll_speed,
    output logic [AW-1:0]    rom_address,
    input  logic [IDX_W-1:0] rom_q,
    output logic [IDX_W-1:0] pal_index,
    input  logic [3:0]       palette_red,
    input  logic [3:0]       palette_green,
    input  logic [3:0]       palette_blue,
    output logic [3:0]       red,
    output logic [3:0]       green,
    output logic [3:0]       blue,
    output logic             opaque,
    output logic [XW-1:0]    scroll_off
);

    localparam int unsigned STEP_X = step(SRC_W, SCR_W, FRAC);
    localparam int unsigned STEP_Y = step(SRC_H, SCR_H, FRAC);
    localparam int unsigned PW     = 10 + 32;
    localparam int unsigned WXW    = XW + 1;

    px_stage_t        s1_d, s1_q;
    logic [PW-1:0]    prod_x_c, prod_y_c;
    logic [WXW-1:0]   wx_c;
    logic [AW-1:0]    addr_d, addr_q;
    logic [1:0]       blank_q;
    logic [IDX_W-1:0] pal_c;
    logic [3:0]       red_d, green_d, blue_d;
    logic [3:0]       red_q, green_q, blue_q;
    logic             opaque_d, opaque_q;

    bg_scroll_ctrl #(
        .SRC_W (SRC_W),
        .XW    (XW)
    ) u_scroll (
        .vga_clk      (vga_clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .scroll_load  (scroll_load),
        .scroll_value (scroll_value),
        .scroll_run   (scroll_run),
        .scroll_speed (scroll_speed),
        .scroll_off   (scroll_off)
    );

    // Stage logic: full-width products before the shift, wrap, address, palette gate.
    always_comb begin
        prod_x_c    = PW'(DrawX) * PW'(STEP_X);
        prod_y_c    = PW'(DrawY) * PW'(STEP_Y);
        s1_d.sx     = COORD_W'(prod_x_c >> FRAC);
        s1_d.sy     = COORD_W'(prod_y_c >> FRAC);
        s1_d.blank  = blank;

        wx_c = WXW'(s1_q.sx) + WXW'(scroll_off);
        if (wx_c >= WXW'(SRC_W)) begin
            wx_c = wx_c - WXW'(SRC_W);
        end
        addr_d = AW'(32'(s1_q.sy) * 32'(SRC_W) + 32'(wx_c));

        // ROM data is only meaningful while the matching blank bit says active.
        pal_c    = blank_q[1] ? rom_q : '0;
        red_d    = blank_q[1] ? palette_red   : 4'd0;
        green_d  = blank_q[1] ? palette_green : 4'd0;
        blue_d   = blank_q[1] ? palette_blue  : 4'd0;
        opaque_d = blank_q[1] && (pal_c != IDX_W'(TRANSP_IDX));
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            s1_q     <= '0;
            addr_q   <= '0;
            blank_q  <= '0;
            red_q    <= '0;
            green_q  <= '0;
            blue_q   <= '0;
            opaque_q <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            addr_q   <= addr_d;
            blank_q  <= {blank_q[0], s1_q.blank};
            red_q    <= red_d;
            green_q  <= green_d;
            blue_q   <= blue_d;
            opaque_q <= opaque_d;
        end
    end

    assign rom_address = addr_q;
    assign pal_index   = pal_c;
    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;
    assign opaque      = opaque_q;

endmodule

// File: tb/tb_scaled_bg_renderer.sv
// Directed bench for scaled_bg_renderer with a behavioural sync ROM and palette.
module tb_scaled_bg_renderer;

    logic        vga_clk = 1'b0;
    logic        reset;
    logic [9:0]  DrawX, DrawY;
    logic        blank, frame_tick, scroll_load, scroll_run;
    logic [8:0]  scroll_value, scroll_speed, scroll_off;
    logic [17:0] rom_address;
    logic [3:0]  rom_q, pal_index;
    logic [3:0]  palette_red, palette_green, palette_blue;
    logic [3:0]  red, green, blue;
    logic        opaque;

    int    n_chk = 0;
    int    n_pass = 0;
    int    n;
    int    mdl_scroll;
    int    hist_a [8];
    bit    hist_b [8];
    string hist_t [8];

    always #5 vga_clk = ~vga_clk;

    scaled_bg_renderer dut (
        .vga_clk       (vga_clk),
        .reset         (reset),
        .DrawX         (DrawX),
        .DrawY         (DrawY),
        .blank         (blank),
        .frame_tick    (frame_tick),
        .scroll_load   (scroll_load),
        .scroll_value  (scroll_value),
        .scroll_run    (scroll_run),
        .scroll_speed  (scroll_speed),
        .rom_address   (rom_address),
        .rom_q         (rom_q),
        .pal_index     (pal_index),
        .palette_red   (palette_red),
        .palette_green (palette_green),
        .palette_blue  (palette_blue),
        .red           (red),
        .green         (green),
        .blue          (blue),
        .opaque        (opaque),
        .scroll_off    (scroll_off)
    );

    function automatic logic [3:0] rom_f(input logic [17:0] a);
        return a[3:0] ^ a[7:4] ^ a[11:8];
    endfunction

    always_ff @(posedge vga_clk) rom_q <= rom_f(rom_address);

    assign palette_red   = pal_index;
    assign palette_green = pal_index ^ 4'hA;
    assign palette_blue  = ~pal_index;

    function automatic int addr_mdl(input int x, input int y, input int s);
        int sx, sy, wx;
        sx = (x * 51200) >> 16;
        sy = (y * 68266) >> 16;
        wx = sx + s;
        if (wx >= 500) wx = wx - 500;
        return sy * 500 + wx;
    endfunction

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic clear_hist();
        for (int i = 0; i < 8; i++) begin
            hist_a[i] = 0;
            hist_b[i] = 1'b0;
            hist_t[i] = "idle";
        end
        n = 8;
    endtask

    // One clock: present a pixel, then check address (1 pixel back) and colour (3 back).
    task automatic px(input int x, input int y, input bit b, input int exp_a, input string tag);
        int         j1, j3;
        logic [3:0] idx;
        logic [12:0] e;
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = b;
        hist_a[n % 8] = exp_a;
        hist_b[n % 8] = b;
        hist_t[n % 8] = tag;
        n++;
        @(posedge vga_clk);
        #1;
        frame_tick  = 1'b0;
        scroll_load = 1'b0;
        scroll_run  = 1'b0;
        j1 = (n - 2) % 8;
        j3 = (n - 4) % 8;
        check_eq({hist_t[j1], ".addr"}, rom_address, hist_a[j1]);
        check_eq({hist_t[j1], ".bound"}, longint'(rom_address < 18'd250000), 1);
        idx = rom_f(18'(hist_a[j3]));
        e = hist_b[j3] ? {idx, idx ^ 4'hA, ~idx, idx != 4'd0} : 13'd0;
        check_eq({hist_t[j3], ".rgbo"}, {red, green, blue, opaque}, e);
    endtask

    task automatic tick(input bit ld, input int val, input bit run, input int spd,
                        input int exp_off, input string tag);
        frame_tick   = 1'b1;
        scroll_load  = ld;
        scroll_value = 9'(val);
        scroll_run   = run;
        scroll_speed = 9'(spd);
        if (ld) mdl_scroll = val;
        else if (run) begin
            mdl_scroll = mdl_scroll + spd;
            if (mdl_scroll >= 500) mdl_scroll = mdl_scroll - 500;
        end
        px(0, 0, 1'b0, addr_mdl(0, 0, mdl_scroll), tag);
        check_eq({tag, ".scroll"}, scroll_off, exp_off);
    endtask

    // Reset with active video and a frame_tick that must be ignored.
    task automatic do_reset(input string tag);
        reset        = 1'b1;
        blank        = 1'b1;
        DrawX        = 10'd300;
        frame_tick   = 1'b1;
        scroll_load  = 1'b1;
        scroll_value = 9'd55;
        @(posedge vga_clk);
        #1;
        frame_tick  = 1'b0;
        scroll_load = 1'b0;
        check_eq({tag, ".rgbo"}, {red, green, blue, opaque}, 0);
        check_eq({tag, ".addr"}, rom_address, 0);
        check_eq({tag, ".pal"}, pal_index, 0);
        check_eq({tag, ".scroll"}, scroll_off, 0);
        @(posedge vga_clk);
        #1;
        clear_hist();
        mdl_scroll = 0;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; DrawX = '0; DrawY = '0; blank = 1'b0;
        frame_tick = 1'b0; scroll_load = 1'b0; scroll_run = 1'b0;
        scroll_value = '0; scroll_speed = '0;
        clear_hist();
        mdl_scroll = 0;
        repeat (2) @(posedge vga_clk);
        #1;
        do_reset("por");

        px(639, 479, 1'b1, 249499, "corner");
        px(0, 0, 1'b1, 0, "transp");
        px(7, 0, 1'b0, 5, "blank0");
        repeat (4) px(0, 0, 1'b0, 0, "idle");

        tick(1'b1, 498, 1'b0, 0, 498, "ld498");
        tick(1'b0, 0, 1'b1, 3, 1, "run_wrap");
        tick(1'b1, 7, 1'b1, 3, 7, "ld_pri");
        tick(1'b0, 0, 1'b0, 0, 7, "no_op");
        px(0, 0, 1'b0, 7, "hold");
        check_eq("hold.scroll", scroll_off, 7);

        tick(1'b1, 10, 1'b0, 0, 10, "ld10");
        px(639, 0, 1'b1, 9, "wrap");
        px(0, 479, 1'b1, 249010, "wrap_y");
        px(320, 240, 1'b1, 124760, "mid");
        repeat (4) px(0, 0, 1'b0, 10, "idle10");

        for (int k = 0; k < 3; k++) px(100 + k, 50, 1'b1, addr_mdl(100 + k, 50, mdl_scroll), "pre_rst");
        do_reset("mid_rst");
        for (int k = 0; k < 8; k++) px(k * 80, 100, 1'b1, addr_mdl(k * 80, 100, 0), "post_rst");

        foreach (hist_a[i]) ;
        for (int r = 0; r < 4; r++) begin
            int row;
            row = (r == 0) ? 0 : (r == 1) ? 1 : (r == 2) ? 240 : 479;
            for (int x = 0; x < 640; x++) px(x, row, 1'b1, addr_mdl(x, row, mdl_scroll), "sweep_row");
        end
        for (int c = 0; c < 2; c++) begin
            for (int y = 0; y < 480; y++) px(c * 639, y, 1'b1, addr_mdl(c * 639, y, mdl_scroll), "sweep_col");
        end
        tick(1'b1, 250, 1'b0, 0, 250, "ld250");
        for (int x = 0; x < 640; x++) px(x, 100, 1'b1, addr_mdl(x, 100, mdl_scroll), "sweep_scr");
        repeat (4) px(0, 0, 1'b0, 250, "flush");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
